// File: rtl/mips32_mem_pkg.sv
// Shared types for the unified instruction/data memory port arbiter.
// Mode and owner-tag encodings are visible on ports and in the bench.
package mips32_mem_pkg;

  localparam int AW_DEF       = 10;
  localparam int DW_DEF       = 32;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2,
    OWN_LD   = 2'd3
  } owner_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of denied fetch cycles; at_max hands fetch the port
// ahead of data traffic.
module mem_arb_starve_cnt
  import mips32_mem_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0] cnt;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_W)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_max = (cnt == MAX_W);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port arbiter for fetch, data and loader access to one synchronous-read
// memory, with run/drain/load mode sequencing and fetch starvation protection.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | pipeline owns the port; data beats fetch unless fetch starved
// ST_DRAIN | one idle cycle so an outstanding read response can land
// ST_LOAD  | loader/debug port owns the port; fetch and data held off
module mem_port_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          core_halt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          if_rvalid,
  output logic          dm_rvalid,
  output logic          ld_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    arb_state
);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  logic       if_win, dm_win, ld_win;
  logic       at_max;
  logic       starve_inc, starve_clr;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (core_halt) state_d = ST_DRAIN;
      ST_DRAIN: state_d = core_halt ? ST_LOAD : ST_RUN;
      ST_LOAD:  if (!core_halt) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Grants are forced low while reset is held, independent of registered state.
  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    ld_win = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_RUN: begin
          if (if_req && at_max) begin
            if_win = 1'b1;
          end else if (dm_req) begin
            dm_win = 1'b1;
          end else if (if_req) begin
            if_win = 1'b1;
          end
        end
        ST_LOAD: ld_win = ld_req;
        default: ;
      endcase
    end
  end

  assign if_gnt = if_win;
  assign dm_gnt = dm_win;
  assign ld_gnt = ld_win;
  assign mem_en = if_win | dm_win | ld_win;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_NONE;
    if (if_win) begin
      mem_addr = if_addr;
      owner_d  = OWN_IF;
    end else if (dm_win) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      owner_d   = dm_we ? OWN_NONE : OWN_DM;
    end else if (ld_win) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      owner_d   = ld_we ? OWN_NONE : OWN_LD;
    end
  end

  // The tag follows every grant, so a response from the last cycle of a mode
  // is still delivered after the mode changes.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign if_rvalid = (owner_q == OWN_IF);
  assign dm_rvalid = (owner_q == OWN_DM);
  assign ld_rvalid = (owner_q == OWN_LD);
  assign rdata     = (owner_q != OWN_NONE) ? mem_rdata : '0;
  assign arb_state = state_q;

  assign starve_inc = (state_q == ST_RUN) && if_req && !if_win;
  assign starve_clr = if_win || ((state_q == ST_DRAIN) && core_halt);

  mem_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (at_max)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a mode/wait
// reference model and a shadow copy of memory contents.
module tb_mem_port_arbiter;
  import mips32_mem_pkg::*;

  localparam int AW       = 10;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;
  localparam int M_RUN    = 0;
  localparam int M_DRAIN  = 1;
  localparam int M_LOAD   = 2;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_halt = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt;
  logic          dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt;
  logic          ld_req = 1'b0, ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_gnt;
  logic          if_rvalid, dm_rvalid, ld_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    arb_state;

  always #5 clk1 = ~clk1;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk1(clk1), .rst_n(rst_n), .core_halt(core_halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .if_rvalid(if_rvalid), .dm_rvalid(dm_rvalid), .ld_rvalid(ld_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .arb_state(arb_state)
  );

  // Synchronous-read memory macro driven by the DUT's port.
  logic [DW-1:0] tb_mem  [1024];
  logic [DW-1:0] ref_mem [1024];

  always @(posedge clk1) begin
    if (mem_en && mem_we) tb_mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= tb_mem[mem_addr];
  end

  int n_vec = 0;
  int n_bad = 0;

  // Requester slots: 0 = fetch, 1 = data, 2 = loader.
  logic          rq [3];
  logic          rw [3];
  logic [AW-1:0] ra [3];
  logic [DW-1:0] rwd[3];

  int            m_mode, m_wait, m_resp;
  logic [DW-1:0] m_rdat;

  logic [2:0]    obs_gnt, obs_rv;
  logic [DW-1:0] obs_rdata;
  logic [1:0]    obs_state;
  logic [2:0]    seq [1:6];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN;
    m_wait = 0;
    m_resp = 0;
    m_rdat = '0;
  endtask

  task automatic issue(input int who, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rq[who]  = 1'b1;
    rw[who]  = we;
    ra[who]  = a;
    rwd[who] = d;
  endtask

  // One clock: drive, predict, compare, then advance the model at the edge.
  task automatic cycle();
    logic [2:0] e_gnt;
    int win;
    if_req   = rq[0]; if_addr  = ra[0];
    dm_req   = rq[1]; dm_we    = rw[1]; dm_addr = ra[1]; dm_wdata = rwd[1];
    ld_req   = rq[2]; ld_we    = rw[2]; ld_addr = ra[2]; ld_wdata = rwd[2];
    #1;
    if (!rst_n) model_reset();
    e_gnt = 3'b000;
    win   = -1;
    if (rst_n) begin
      if (m_mode == M_RUN) begin
        if (rq[0] && m_wait == MAX_WAIT) win = 0;
        else if (rq[1])                  win = 1;
        else if (rq[0])                  win = 0;
      end else if (m_mode == M_LOAD && rq[2]) begin
        win = 2;
      end
    end
    if (win >= 0) e_gnt[2-win] = 1'b1;
    obs_gnt   = {if_gnt, dm_gnt, ld_gnt};
    obs_rv    = {if_rvalid, dm_rvalid, ld_rvalid};
    obs_rdata = rdata;
    obs_state = arb_state;
    chk("gnt", 32'(obs_gnt), 32'(e_gnt));
    chk("rvalid", 32'(obs_rv), 32'({m_resp == 1, m_resp == 2, m_resp == 3}));
    chk("rdata", obs_rdata, (m_resp != 0) ? m_rdat : '0);
    chk("arb_state", 32'(obs_state), 32'(m_mode));
    chk("mem_en", 32'(mem_en), 32'(win >= 0));
    if (win >= 0) begin
      chk("mem_addr", 32'(mem_addr), 32'(ra[win]));
      chk("mem_we", 32'(mem_we), 32'(rw[win]));
      if (rw[win]) chk("mem_wdata", mem_wdata, rwd[win]);
    end
    @(posedge clk1);
    if (rst_n) begin
      m_resp = 0;
      if (m_mode == M_RUN) begin
        if (win == 0)  m_wait = 0;
        else if (rq[0]) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      end
      if (win >= 0) begin
        if (rw[win]) ref_mem[ra[win]] = rwd[win];
        else begin
          m_resp = win + 1;
          m_rdat = ref_mem[ra[win]];
        end
        rq[win] = 1'b0;
      end
      case (m_mode)
        M_RUN:   if (core_halt) m_mode = M_DRAIN;
        M_DRAIN: if (core_halt) begin m_mode = M_LOAD; m_wait = 0; end
                 else m_mode = M_RUN;
        default: if (!core_halt) m_mode = M_RUN;
      endcase
    end
    @(negedge clk1);
  endtask

  task automatic rand_traffic();
    if (!rq[0] && $urandom_range(0, 2) == 0) issue(0, 1'b0, AW'($urandom_range(0, 63)), '0);
    if (!rq[1] && $urandom_range(0, 1) == 0)
      issue(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom);
    if (!rq[2] && $urandom_range(0, 3) == 0)
      issue(2, ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 63)), $urandom);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      tb_mem[i]  = 32'hC0DE_0000 | 32'(i);
      ref_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    for (int i = 0; i < 3; i++) begin
      rq[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rwd[i] = '0;
    end
    model_reset();
    repeat (2) @(negedge clk1);
    cycle();
    rst_n = 1'b1;

    // Reset mid-read, then a fetch pending across reset release.
    issue(1, 1'b0, 10'h033, '0);
    cycle();
    rst_n = 1'b0;
    cycle();
    chk("rst_rvalid_drop", 32'(obs_rv), 32'd0);
    chk("rst_state", 32'(obs_state), 32'(M_RUN));
    issue(0, 1'b0, 10'd5, '0);
    cycle();
    chk("rst_no_gnt", 32'(obs_gnt), 32'd0);
    rst_n = 1'b1;
    cycle();
    chk("rst_if_gnt", 32'(obs_gnt), 32'b100);
    cycle();
    chk("rst_if_rvalid", 32'(obs_rv), 32'b100);
    chk("rst_if_data", obs_rdata, 32'hC0DE_0005);

    // Continuous data traffic against one fetch: fetch wins in cycle MAX_WAIT+1.
    issue(0, 1'b0, 10'h007, '0);
    for (int k = 1; k <= 6; k++) begin
      if (!rq[1]) issue(1, 1'b0, 10'h010, '0);
      cycle();
      seq[k] = obs_gnt;
    end
    for (int k = 1; k <= 6; k++)
      chk($sformatf("starve_c%0d", k), 32'(seq[k]), (k == MAX_WAIT + 1) ? 32'b100 : 32'b010);

    // Write then read back.
    issue(1, 1'b1, 10'h020, 32'hDEAD_BEEF);
    cycle();
    issue(1, 1'b0, 10'h020, '0);
    cycle();
    chk("wr_no_rvalid", 32'(obs_rv), 32'd0);
    cycle();
    chk("rd_back_rvalid", 32'(obs_rv), 32'b010);
    chk("rd_back_data", obs_rdata, 32'hDEAD_BEEF);

    // Halt with a read in flight, drain, load, resume.
    issue(1, 1'b0, 10'h021, '0);
    core_halt = 1'b1;
    cycle();
    chk("halt_dm_gnt", 32'(obs_gnt), 32'b010);
    issue(0, 1'b0, 10'd0, '0);
    cycle();
    chk("drain_state", 32'(obs_state), 32'(M_DRAIN));
    chk("drain_dm_rvalid", 32'(obs_rv), 32'b010);
    chk("drain_no_gnt", 32'(obs_gnt), 32'd0);
    for (int k = 0; k < 4; k++) begin
      issue(2, 1'b1, AW'(k), 32'hB000_0000 + 32'(k));
      cycle();
      chk("load_ld_gnt", 32'(obs_gnt), 32'b001);
    end
    core_halt = 1'b0;
    cycle();
    chk("load_exit_state", 32'(obs_state), 32'(M_LOAD));
    cycle();
    chk("resume_if_gnt", 32'(obs_gnt), 32'b100);
    chk("resume_state", 32'(obs_state), 32'(M_RUN));
    cycle();
    chk("resume_fetch_data", obs_rdata, 32'hB000_0000);

    // Loader request in RUN is never granted.
    issue(2, 1'b1, 10'h030, 32'h1234_5678);
    for (int k = 0; k < 10; k++) begin
      rand_traffic();
      cycle();
      chk("ld_in_run", 32'(obs_gnt[0]), 32'd0);
    end

    // Single-cycle halt pulse: one bubble, back to RUN.
    core_halt = 1'b1;
    rand_traffic();
    cycle();
    core_halt = 1'b0;
    rand_traffic();
    cycle();
    chk("pulse_drain", 32'(obs_state), 32'(M_DRAIN));
    chk("pulse_bubble", 32'(obs_gnt), 32'd0);
    cycle();
    chk("pulse_run", 32'(obs_state), 32'(M_RUN));
    chk("pulse_no_ld", 32'(obs_gnt[0]), 32'd0);

    // Random traffic with mode changes and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rand_traffic();
      if ($urandom_range(0, 39) == 0) core_halt = ~core_halt;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
